arbitro_vc_ponderado: RTL and testbench

Weighted arbiter and dispatcher between the two virtual-channel FIFOs (VC0, VC1) and the two downstream destination FIFOs (D0, D1) of the transmission layer. It pops at most one word per cycle from VC0 or VC1. VC0 has priority, subject to a fairness weight that bounds VC1 starvation. One cycle after each pop, it routes the word to D0 or D1 by its destination bit. All pops are withheld while either destination FIFO is full or almost full.

---
 rtl/arbitro_pkg.sv | 18 +
 rtl/dispatch_reg.sv | 60 ++++++
 rtl/arbitro_vc_ponderado.sv | 124 ++++++++++++
 tb/tb_arbitro_vc_ponderado.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the weighted VC arbiter/dispatcher.
// Provides default widths, the destination-bit position, the fairness
// weight default and the FSM state encoding used by the top level.
package arbitro_pkg;

  localparam int unsigned DATA_W_DEF   = 6;
  localparam int unsigned DEST_BIT_DEF = 4;
  localparam int unsigned WEIGHT_DEF   = 4;
  localparam int unsigned RUN_W        = 3;
  localparam int unsigned STATE_W      = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_PAUSE  = 2'b10
  } state_t;

endpackage : arbitro_pkg

// File: rtl/dispatch_reg.sv
// Dispatch stage: remembers which VC was popped last cycle, selects that
// VC's read data (valid one cycle after the pop) and pushes it into D0 or
// D1 according to the destination bit.
// Ports:
//   clk, reset_L          clock, async active-low reset
//   pop                   a pop happened this cycle (either VC)
//   sel                   pop source this cycle (0 = VC0, 1 = VC1)
//   data_VC0, data_VC1    VC read data, valid the cycle after the pop
//   push_D0, push_D1      registered push strobes
//   data_out              registered word for D0/D1
module dispatch_reg
  import arbitro_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEST_BIT = DEST_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              pop,
  input  logic              sel,
  input  logic [DATA_W-1:0] data_VC0,
  input  logic [DATA_W-1:0] data_VC1,
  output logic              push_D0,
  output logic              push_D1,
  output logic [DATA_W-1:0] data_out
);

  logic              pop_q;
  logic              sel_q;
  logic [DATA_W-1:0] word_c;

  // Pop bookkeeping for the word arriving next cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_q <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      pop_q <= pop;
      sel_q <= sel;
    end
  end

  assign word_c = sel_q ? data_VC1 : data_VC0;

  // Route the arriving word by its destination bit; data_out holds between words.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_D0  <= 1'b0;
      push_D1  <= 1'b0;
      data_out <= '0;
    end else begin
      push_D0 <= pop_q & ~word_c[DEST_BIT];
      push_D1 <= pop_q &  word_c[DEST_BIT];
      if (pop_q) begin
        data_out <= word_c;
      end
    end
  end

endmodule : dispatch_reg

// File: rtl/arbitro_vc_ponderado.sv
// Weighted arbiter between VC0/VC1 and dispatcher into D0/D1.
// VC0 wins unless it has already taken WEIGHT_VC0 consecutive pops while
// VC1 was waiting; all pops stop while any destination is (almost) full.
// Ports:
//   clk, reset_L                  clock, async active-low reset
//   VC0_empty, VC1_empty          VC FIFO empty flags
//   data_VC0, data_VC1            VC read data (valid cycle after pop)
//   full_fifo_D*, almost_full_*   destination back-pressure
//   VC0_pop, VC1_pop              combinational pop strobes
//   push_D0, push_D1, data_out    registered dispatch outputs
//   state                         FSM state (IDLE/ACTIVE/PAUSE)
//   vc0_run                       consecutive VC0 pops while VC1 waits
module arbitro_vc_ponderado
  import arbitro_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEST_BIT   = DEST_BIT_DEF,
  parameter int unsigned WEIGHT_VC0 = WEIGHT_DEF
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               VC0_empty,
  input  logic               VC1_empty,
  input  logic [DATA_W-1:0]  data_VC0,
  input  logic [DATA_W-1:0]  data_VC1,
  input  logic               full_fifo_D0,
  input  logic               full_fifo_D1,
  input  logic               almost_full_fifo_D0,
  input  logic               almost_full_fifo_D1,
  output logic               VC0_pop,
  output logic               VC1_pop,
  output logic               push_D0,
  output logic               push_D1,
  output logic [DATA_W-1:0]  data_out,
  output logic [STATE_W-1:0] state,
  output logic [RUN_W-1:0]   vc0_run
);

  localparam logic [RUN_W-1:0] WEIGHT_R = RUN_W'(WEIGHT_VC0);

  logic             pause_c;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  state_t           state_q;
  state_t           state_d;

  assign pause_c = full_fifo_D0 | almost_full_fifo_D0 |
                   full_fifo_D1 | almost_full_fifo_D1;

  // Grant: reset and pause gate everything; VC0 first until its run hits the weight.
  always_comb begin
    VC0_pop = 1'b0;
    VC1_pop = 1'b0;
    if (reset_L && !pause_c) begin
      if (!VC0_empty && (VC1_empty || (run_q < WEIGHT_R))) begin
        VC0_pop = 1'b1;
      end else if (!VC1_empty) begin
        VC1_pop = 1'b1;
      end
    end
  end

  // Run length only grows while VC1 is actually waiting.
  always_comb begin
    run_d = run_q;
    if (VC1_pop) begin
      run_d = '0;
    end else if (VC0_pop) begin
      if (VC1_empty) begin
        run_d = '0;
      end else if (run_q < WEIGHT_R) begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: pause outranks pending data.
  always_comb begin
    state_d = state_q;
    if (pause_c) begin
      state_d = ST_PAUSE;
    end else if (!VC0_empty || !VC1_empty) begin
      state_d = ST_ACTIVE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  assign state   = state_q;
  assign vc0_run = run_q;

  dispatch_reg #(
    .DATA_W   (DATA_W),
    .DEST_BIT (DEST_BIT)
  ) u_dispatch (
    .clk      (clk),
    .reset_L  (reset_L),
    .pop      (VC0_pop | VC1_pop),
    .sel      (VC1_pop),
    .data_VC0 (data_VC0),
    .data_VC1 (data_VC1),
    .push_D0  (push_D0),
    .push_D1  (push_D1),
    .data_out (data_out)
  );

endmodule : arbitro_vc_ponderado

// File: tb/tb_arbitro_vc_ponderado.sv
// Bench for arbitro_vc_ponderado: VC FIFOs are modelled as queues with
// read data appearing the cycle after the pop; a behavioural model tracks
// expected grants, run length, FSM state and the pushes two cycles later.
module tb_arbitro_vc_ponderado;

  localparam int unsigned DW   = 6;
  localparam int unsigned DB   = 4;
  localparam int unsigned WGT  = 4;
  localparam int unsigned QCAP = 8;

  logic          clk;
  logic          reset_L;
  logic          VC0_empty, VC1_empty;
  logic [DW-1:0] data_VC0, data_VC1;
  logic          full_fifo_D0, full_fifo_D1;
  logic          almost_full_fifo_D0, almost_full_fifo_D1;
  logic          VC0_pop, VC1_pop;
  logic          push_D0, push_D1;
  logic [DW-1:0] data_out;
  logic [1:0]    state;
  logic [2:0]    vc0_run;

  arbitro_vc_ponderado #(
    .DATA_W     (DW),
    .DEST_BIT   (DB),
    .WEIGHT_VC0 (WGT)
  ) dut (
    .clk                 (clk),
    .reset_L             (reset_L),
    .VC0_empty           (VC0_empty),
    .VC1_empty           (VC1_empty),
    .data_VC0            (data_VC0),
    .data_VC1            (data_VC1),
    .full_fifo_D0        (full_fifo_D0),
    .full_fifo_D1        (full_fifo_D1),
    .almost_full_fifo_D0 (almost_full_fifo_D0),
    .almost_full_fifo_D1 (almost_full_fifo_D1),
    .VC0_pop             (VC0_pop),
    .VC1_pop             (VC1_pop),
    .push_D0             (push_D0),
    .push_D1             (push_D1),
    .data_out            (data_out),
    .state               (state),
    .vc0_run             (vc0_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] d0_nxt, d1_nxt;
  int unsigned   m_run;
  logic [1:0]    m_state;
  bit            m_s1_v;
  logic [DW-1:0] m_s1_w;
  bit            m_push_v;
  logic [DW-1:0] m_push_w;
  logic [DW-1:0] m_dout;
  int            n_pops0, n_pops1, n_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    d0_nxt   = '0;
    d1_nxt   = '0;
    m_run    = 0;
    m_state  = 2'b00;
    m_s1_v   = 1'b0;
    m_s1_w   = '0;
    m_push_v = 1'b0;
    m_push_w = '0;
    m_dout   = '0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic cycle(input bit f0, input bit a0, input bit f1, input bit a1,
                       input int pct0, input int pct1);
    bit pause, g0, g1, e0, e1;
    logic [DW-1:0] w;
    @(negedge clk);
    if ($urandom_range(99) < pct0 && q0.size() < QCAP) q0.push_back(DW'($urandom));
    if ($urandom_range(99) < pct1 && q1.size() < QCAP) q1.push_back(DW'($urandom));
    data_VC0 = d0_nxt;
    data_VC1 = d1_nxt;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    VC0_empty = e0;
    VC1_empty = e1;
    full_fifo_D0 = f0;
    almost_full_fifo_D0 = a0;
    full_fifo_D1 = f1;
    almost_full_fifo_D1 = a1;
    #1;
    pause = f0 | a0 | f1 | a1;
    g0 = !pause && !e0 && (e1 || m_run < WGT);
    g1 = !pause && !g0 && !e1;
    chk("vc0_pop", 32'(VC0_pop), 32'(g0));
    chk("vc1_pop", 32'(VC1_pop), 32'(g1));
    chk("state",   32'(state),   32'(m_state));
    chk("vc0_run", 32'(vc0_run), m_run);
    chk("push_d0", 32'(push_D0), 32'(m_push_v && !m_push_w[DB]));
    chk("push_d1", 32'(push_D1), 32'(m_push_v &&  m_push_w[DB]));
    chk("data_out", 32'(data_out), 32'(m_dout));
    if (push_D0 && push_D1) chk("push_both", 32'd1, 32'(0));
    // Advance model across the coming rising edge
    m_push_v = m_s1_v;
    m_push_w = m_s1_w;
    if (m_s1_v) begin
      m_dout = m_s1_w;
      n_push++;
    end
    m_s1_v = g0 | g1;
    if (g0) begin
      w = q0.pop_front();
      d0_nxt = w;
      m_s1_w = w;
      n_pops0++;
      m_run = e1 ? 0 : ((m_run < WGT) ? m_run + 1 : m_run);
    end else if (g1) begin
      w = q1.pop_front();
      d1_nxt = w;
      m_s1_w = w;
      n_pops1++;
      m_run = 0;
    end
    m_state = pause ? 2'b10 : ((!e0 || !e1) ? 2'b01 : 2'b00);
  endtask

  task automatic do_reset_midstream();
    @(negedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    chk("rst_vc0_pop", 32'(VC0_pop), 32'(0));
    chk("rst_vc1_pop", 32'(VC1_pop), 32'(0));
    chk("rst_push_d0", 32'(push_D0), 32'(0));
    chk("rst_push_d1", 32'(push_D1), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_vc0_run", 32'(vc0_run), 32'(0));
    model_clear();
    VC0_empty = 1'b1;
    VC1_empty = 1'b1;
    data_VC0 = '0;
    data_VC1 = '0;
    full_fifo_D0 = 1'b0;
    full_fifo_D1 = 1'b0;
    almost_full_fifo_D0 = 1'b0;
    almost_full_fifo_D1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    n_pops0 = 0;
    n_pops1 = 0;
    n_push  = 0;
    model_clear();
    reset_L = 1'b0;
    VC0_empty = 1'b1;
    VC1_empty = 1'b1;
    data_VC0 = '0;
    data_VC1 = '0;
    full_fifo_D0 = 1'b0;
    full_fifo_D1 = 1'b0;
    almost_full_fifo_D0 = 1'b0;
    almost_full_fifo_D1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_state", 32'(state), 32'(0));
    chk("init_push_d0", 32'(push_D0), 32'(0));
    chk("init_data_out", 32'(data_out), 32'(0));
    reset_L = 1'b1;

    // VC0 only: three words with destinations 0,1,0
    q0.push_back(6'h03);
    q0.push_back(6'h15);
    q0.push_back(6'h0A);
    repeat (6) cycle(0, 0, 0, 0, 0, 0);

    // Both VCs kept full: VC0 x WEIGHT then VC1 x 1
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'($urandom));
      q1.push_back(DW'($urandom));
    end
    repeat (25) cycle(0, 0, 0, 0, 100, 100);

    // almost_full on D1 for 5 cycles mid-stream
    repeat (5) cycle(0, 0, 0, 1, 100, 100);
    repeat (4) cycle(0, 0, 0, 0, 100, 100);

    // Drain, then VC0 one word and VC1 two words
    repeat (20) cycle(0, 0, 0, 0, 0, 0);
    q0.push_back(DW'($urandom));
    q1.push_back(DW'($urandom));
    q1.push_back(DW'($urandom));
    repeat (6) cycle(0, 0, 0, 0, 0, 0);

    // Pause with both VCs empty
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset mid-stream with VC0 holding 3 words
    repeat (4) cycle(0, 0, 0, 0, 100, 60);
    while (q0.size() < 3) q0.push_back(DW'($urandom));
    cycle(0, 0, 0, 0, 0, 0);
    do_reset_midstream();
    repeat (4) cycle(0, 0, 0, 0, 0, 0);

    // Randomized traffic and back-pressure
    for (int i = 0; i < 3000; i++) begin
      bit hold;
      hold = ($urandom_range(99) < 20);
      cycle(hold && $urandom_range(3) == 0, hold && $urandom_range(3) == 1,
            hold && $urandom_range(3) == 2, hold && $urandom_range(3) == 3,
            int'($urandom_range(100)), int'($urandom_range(100)));
    end

    chk("vc1_pops_seen", 32'(n_pops1 > 50), 32'(1));
    chk("vc0_pops_seen", 32'(n_pops0 > 50), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_arbitro_vc_ponderado
